// File: rtl/uart_rx_os.sv
// uart_rx_os - parametrised UART receiver with 16x oversampling.
//
// Receives asynchronous serial frames: 1 start bit, DATA_BITS payload bits
// (LSB first), an optional parity bit and STOP_BITS stop bits. Each bit is
// decided by a 3-sample majority vote around the bit centre. Short low
// glitches on an idle line are rejected during the start bit.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rx          serial line (asynchronous, idle high)
//   data        received payload
//   valid       data/flags valid, held until accepted with ready
//   ready       consumer accept (valid && ready)
//   busy        frame reception in progress
//   frame_err   a stop bit was sampled low (qualified by valid)
//   parity_err  parity mismatch (qualified by valid, 0 when PARITY=0)
//   overrun     1-cycle pulse: frame completed while valid was still high
//   break_det   1-cycle pulse: break frame received
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCW      = $clog2(OVERSAMPLE);
  localparam int BCW      = $clog2(DATA_BITS);
  localparam int MID      = OVERSAMPLE / 2;

  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [SCW-1:0] SMP_LO    = SCW'(MID - 1);
  localparam logic [SCW-1:0] SMP_MID   = SCW'(MID);
  localparam logic [SCW-1:0] SMP_HI    = SCW'(MID + 1);
  localparam logic [SCW-1:0] SMP_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [SCW-1:0]       samp_q, samp_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 pbit_q, pbit_d;
  logic                 stop0_low_q, stop0_low_d;
  logic                 done_q, done_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 break_det_q, break_det_d;

  logic           tick;
  logic [SCW-1:0] samp_nxt;
  logic           at_lo, at_mid, at_hi, at_end;
  logic           maj;
  logic           brk_now;

  // Tick generator and sample position decode. The sample index of a tick
  // is the value the sample counter advances to on that tick; the tick that
  // detects the start edge is sample 0.
  always_comb begin
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    samp_nxt   = (samp_q == SMP_LAST) ? '0 : samp_q + 1'b1;
    at_lo      = tick && (samp_nxt == SMP_LO);
    at_mid     = tick && (samp_nxt == SMP_MID);
    at_hi      = tick && (samp_nxt == SMP_HI);
    at_end     = tick && (samp_nxt == '0);
    maj        = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    // A break needs the first stop bit low; with one stop bit that is the
    // bit being resolved right now.
    brk_now    = (shreg_q == '0) && ((PARITY == 0) || !pbit_q) &&
                 ((stop_cnt_q == 1'b0) ? !maj : stop0_low_q);
  end

  // Frame state machine
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    shreg_d     = shreg_q;
    ferr_d      = ferr_q;
    perr_d      = perr_q;
    pbit_d      = pbit_q;
    stop0_low_d = stop0_low_q;
    done_d      = 1'b0;
    brk_d       = 1'b0;

    if (state_q != S_IDLE) begin
      if (tick)   samp_d = samp_nxt;
      if (at_lo)  s0_d   = rx_s_q;
      if (at_mid) s1_d   = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && !rx_s_q) begin
          state_d     = S_START;
          samp_d      = '0;
          bit_cnt_d   = '0;
          stop_cnt_d  = 1'b0;
          ferr_d      = 1'b0;
          perr_d      = 1'b0;
          pbit_d      = 1'b0;
          stop0_low_d = 1'b0;
        end
      end
      S_START: begin
        if (at_hi && maj)   state_d = S_IDLE;
        else if (at_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (at_hi) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (at_hi) begin
          pbit_d = maj;
          perr_d = (PARITY == 2) ? ~(^shreg_q ^ maj) : (^shreg_q ^ maj);
        end
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_hi) begin
          if (!maj) ferr_d = 1'b1;
          if (stop_cnt_q == 1'b0) stop0_low_d = !maj;
          // Complete at the centre of the last stop bit so a start edge
          // right after it is still caught.
          if (stop_cnt_q == STOP_LAST) begin
            done_d  = 1'b1;
            brk_d   = brk_now;
            state_d = brk_now ? S_BRK_WAIT : S_IDLE;
          end
        end else if (at_end) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      S_BRK_WAIT: begin
        if (tick && rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delivery / handshake
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    break_det_d  = 1'b0;
    if (done_q) begin
      break_det_d = brk_q;
      // An accept in the completion cycle frees the slot for the new frame.
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d       = shreg_q;
        frame_err_d  = ferr_q;
        parity_err_d = (PARITY != 0) && perr_q;
        valid_d      = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      samp_q       <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shreg_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      pbit_q       <= 1'b0;
      stop0_low_q  <= 1'b0;
      done_q       <= 1'b0;
      brk_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_q       <= samp_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shreg_q      <= shreg_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      pbit_q       <= pbit_d;
      stop0_low_q  <= stop0_low_d;
      done_q       <= done_d;
      brk_q        <= brk_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;

endmodule
